aes_pipe_ctrl: RTL and testbench

AES_PIPE_CTRL -- requirements
Module: aes_pipe_ctrl

---
 rtl/aes_pipe_ctrl.sv | 157 +++++++++++++++
 tb/tb_aes_pipe_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// aes_pipe_ctrl
//
// Control plane for a fully pipelined AES datapath. Sequences the round-key
// load, admits plaintext blocks against an output-FIFO credit count, and
// carries a valid tag alongside every datapath register stage.
//
// Handshake: a block is accepted in any cycle where in_valid && in_ready.
// in_ready never depends on in_valid. The pipeline never stalls, so an
// accepted block leaves as out_valid exactly LATENCY cycles later; downstream
// returns one credit per out_pop.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   key_load   one-cycle request for a new key expansion
//   in_valid   upstream has a plaintext block
//   in_ready   block accepted this cycle when in_valid is also high
//   out_pop    downstream removed one FIFO entry (one credit back)
//   stage_vld  per-stage valid tags, bit 0 = first datapath stage
//   out_valid  ciphertext valid at datapath output (FIFO write enable)
//   rk_we      round-key register write enable
//   rk_idx     round-key index written while rk_we is high
//   key_ready  a complete key schedule is loaded
//   busy       expanding/draining, or any block in flight
//   state_dbg  current FSM state (IDLE=0, KEYEXP=1, RUN=2, DRAIN=3)
// -----------------------------------------------------------------------------
module aes_pipe_ctrl #(
    parameter int LATENCY = 31,
    parameter int NR      = 10,
    parameter int CREDITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               key_load,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               out_pop,
    output logic [LATENCY-1:0] stage_vld,
    output logic               out_valid,
    output logic               rk_we,
    output logic [3:0]         rk_idx,
    output logic               key_ready,
    output logic               busy,
    output logic [1:0]         state_dbg
);

    localparam int          CW       = $clog2(CREDITS + 1);
    localparam logic [3:0]  LAST_IDX = 4'(NR);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_KEYEXP = 2'd1,
        S_RUN    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [3:0]    idx_q;
    logic [3:0]    idx_next;
    logic          key_ready_next;
    logic [CW-1:0] credit_cnt;
    logic [CW-1:0] credit_next;
    logic          accept;

    // Next-state and Moore/Mealy outputs.
    always_comb begin
        state_next     = state;
        idx_next       = idx_q;
        key_ready_next = key_ready;
        in_ready       = 1'b0;
        rk_we          = 1'b0;
        case (state)
            S_IDLE: begin
                if (key_load) begin
                    state_next     = S_KEYEXP;
                    idx_next       = 4'd0;
                    key_ready_next = 1'b0;
                end
            end
            S_KEYEXP: begin
                rk_we = 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Index holds at NR after the schedule completes.
                    state_next     = S_RUN;
                    key_ready_next = 1'b1;
                end else begin
                    idx_next = idx_q + 4'd1;
                end
            end
            S_RUN: begin
                // A key_load cycle is never an accept cycle, so nothing new
                // enters the pipe once the reload decision is taken.
                in_ready = (credit_cnt != '0) && !key_load;
                if (key_load) begin
                    if (|stage_vld) begin
                        state_next = S_DRAIN;
                    end else begin
                        state_next     = S_KEYEXP;
                        idx_next       = 4'd0;
                        key_ready_next = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                // Nothing enters during DRAIN, so once only the last stage
                // can still hold a block the pipe is empty next cycle and
                // KEYEXP starts right after the final out_valid.
                if (stage_vld[LATENCY-2:0] == '0) begin
                    state_next     = S_KEYEXP;
                    idx_next       = 4'd0;
                    key_ready_next = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign accept = in_valid && in_ready;

    // Credit bookkeeping: simultaneous accept and pop cancel; pops beyond
    // the full count are dropped.
    always_comb begin
        credit_next = credit_cnt;
        if (accept && !out_pop) begin
            credit_next = credit_cnt - CW'(1);
        end else if (!accept && out_pop && (credit_cnt != CRED_MAX)) begin
            credit_next = credit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx_q      <= 4'd0;
            key_ready  <= 1'b0;
            credit_cnt <= CRED_MAX;
            stage_vld  <= '0;
        end else begin
            state      <= state_next;
            idx_q      <= idx_next;
            key_ready  <= key_ready_next;
            credit_cnt <= credit_next;
            stage_vld  <= {stage_vld[LATENCY-2:0], accept};
        end
    end

    assign out_valid = stage_vld[LATENCY-1];
    assign rk_idx    = idx_q;
    assign busy      = (state == S_KEYEXP) || (state == S_DRAIN) || (|stage_vld);
    assign state_dbg = state;

endmodule

// File: tb/tb_aes_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_pipe_ctrl
//
// Randomised bench for aes_pipe_ctrl. The reference model tracks the block
// in flight as a queue of exit cycles, a credit integer, and a coarse mode;
// expected stage tags, busy and out_valid timing are all derived from that
// queue of exit cycles.
// -----------------------------------------------------------------------------
module tb_aes_pipe_ctrl;

    localparam int LAT  = 31;
    localparam int NR   = 10;
    localparam int CRED = 4;

    localparam int M_IDLE  = 0;
    localparam int M_KEX   = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           key_load = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_pop  = 1'b0;
    logic           in_ready;
    logic [LAT-1:0] stage_vld;
    logic           out_valid;
    logic           rk_we;
    logic [3:0]     rk_idx;
    logic           key_ready;
    logic           busy;
    logic [1:0]     state_dbg;

    aes_pipe_ctrl #(.LATENCY(LAT), .NR(NR), .CREDITS(CRED)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pop   (out_pop),
        .stage_vld (stage_vld),
        .out_valid (out_valid),
        .rk_we     (rk_we),
        .rk_idx    (rk_idx),
        .key_ready (key_ready),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];   // cycle in which each accepted block must exit

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // ---------------- reference model state ----------------
    int m_mode      = M_IDLE;
    int m_cred      = CRED;
    int m_kex_start = 0;
    int m_last_idx  = 0;
    int m_drain_to  = 0;
    int m_seen_idx  = -1;
    logic m_key_rdy = 1'b0;

    task automatic model_reset();
        m_mode     = M_IDLE;
        m_cred     = CRED;
        m_last_idx = 0;
        m_key_rdy  = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("out_valid_unexpected", 64'd1, 64'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("out_valid_cycle", 64'(cyc), 64'(e));
                end
            end else if (exp_q.size() > 0 && exp_q[0] <= 32'(cyc)) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("out_valid_missing", 64'(cyc), 64'(e));
            end
        end
    end

    // ---------------- driver + model step ----------------
    task automatic step(input logic kl, input logic iv, input logic pop);
        logic [LAT-1:0] ev;
        logic exp_ir;
        logic acc;
        int idx;
        @(negedge clk);
        key_load = kl;
        in_valid = iv;
        out_pop  = pop;
        #1;
        exp_ir = (m_mode == M_RUN) && (m_cred > 0) && !kl;
        idx    = (m_mode == M_KEX) ? (cyc - m_kex_start) : m_last_idx;
        m_seen_idx = (m_mode == M_KEX) ? idx : -1;
        ev = '0;
        foreach (exp_q[i]) begin
            if (exp_q[i] >= 32'(cyc) && (int'(exp_q[i]) - cyc) < LAT)
                ev[LAT-1-(int'(exp_q[i]) - cyc)] = 1'b1;
        end
        chk("in_ready",  64'(in_ready),  64'(exp_ir));
        chk("rk_we",     64'(rk_we),     64'(m_mode == M_KEX));
        chk("rk_idx",    64'(rk_idx),    64'(idx));
        chk("key_ready", 64'(key_ready), 64'(m_key_rdy));
        chk("busy",      64'(busy),      64'((m_mode == M_KEX) || (m_mode == M_DRAIN) || (exp_q.size() > 0)));
        chk("stage_vld", 64'(stage_vld), 64'(ev));

        acc = iv && exp_ir;
        if (acc) exp_q.push_back(32'(cyc + LAT));
        if (acc && !pop) m_cred--;
        else if (!acc && pop && m_cred < CRED) m_cred++;

        case (m_mode)
            M_IDLE: if (kl) begin
                m_mode = M_KEX; m_kex_start = cyc + 1; m_key_rdy = 1'b0;
            end
            M_KEX: if (cyc - m_kex_start == NR) begin
                m_mode = M_RUN; m_key_rdy = 1'b1; m_last_idx = NR;
            end
            M_RUN: if (kl) begin
                if (exp_q.size() > 0) begin
                    m_mode     = M_DRAIN;
                    m_drain_to = int'(exp_q[exp_q.size()-1]) + 1;
                    if (m_drain_to < cyc + 2) m_drain_to = cyc + 2;
                end else begin
                    m_mode = M_KEX; m_kex_start = cyc + 1; m_key_rdy = 1'b0;
                end
            end
            default: if (cyc + 1 == m_drain_to) begin
                m_mode = M_KEX; m_kex_start = cyc + 1; m_key_rdy = 1'b0;
            end
        endcase
    endtask

    task automatic idle_until_run();
        for (int i = 0; i < 80 && m_mode != M_RUN; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_pulse();
        key_load = 1'b0; in_valid = 1'b0; out_pop = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_rk_we",     64'(rk_we),     64'd0);
        chk("rst_rk_idx",    64'(rk_idx),    64'd0);
        chk("rst_key_ready", 64'(key_ready), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_stage_vld", 64'(stage_vld), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state before any clock edge.
        #1;
        chk("init_in_ready",  64'(in_ready),  64'd0);
        chk("init_busy",      64'(busy),      64'd0);
        chk("init_stage_vld", 64'(stage_vld), 64'd0);
        chk("init_key_ready", 64'(key_ready), 64'd0);
        chk("init_rk_idx",    64'(rk_idx),    64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Blocks offered before any key load are refused.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

        // Key expansion, then streaming with no credits returned.
        step(1'b1, 1'b0, 1'b0);
        idle_until_run();
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0);

        // Return credits; pops with a full count are discarded.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);

        // Simultaneous accept and pop at low credit counts.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);

        // Reload with a block in flight forces a drain.
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(1'(($urandom_range(0, 3) == 0)), 1'b1, 1'(($urandom_range(0, 1))));
        idle_until_run();

        // Randomised traffic with occasional reloads.
        for (int i = 0; i < 400; i++) begin
            step(1'(($urandom_range(0, 59) == 0)),
                 1'(($urandom_range(0, 1))),
                 1'(($urandom_range(0, 9) < 4)));
        end
        idle_until_run();

        // Reset in the middle of a key expansion at index 6.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 80 && m_seen_idx != 6; i++) step(1'b0, 1'b0, 1'b1);
        chk("reached_idx6", 64'(rk_idx), 64'd6);
        reset_pulse();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle_until_run();
        for (int i = 0; i < 20; i++) step(1'b0, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));

        // Let everything in flight exit.
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
